cmn_entry_alloc_multi: RTL and testbench
========================================

# cmn_entry_alloc_multi

Parametrised multi-port entry allocator: tracks the busy/free state of ENTRY_NUM entries and hands out up to ALLOC_NUM free entries per cycle, using a selectable priority direction (highest index first or lowest index first). Entries are returned through a release mask. Occupancy is maintained by an incremental counter. It sits in front of issue-queue, ROB and buffer entry pools, and replaces per-pool combinational leading-one finders with a single stateful allocator.

## Interface
Parameters:
- ENTRY_NUM, 16, number of tracked entries; must be ≥2.
- ALLOC_NUM, 2, number of allocation slots per cycle; must satisfy 1 ≤ ALLOC_NUM ≤ ENTRY_NUM.
- MSB_FIRST, 1, priority direction: 1 searches from index ENTRY_NUM-1 downward, 0 searches from index 0 upward.
- AWIDTH, $clog2(ENTRY_NUM), localparam.

Ports:
- clk  in  1  clock; every register is updated on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- alloc_req  in  ALLOC_NUM  per-slot allocation request.
- alloc_gnt  out  ALLOC_NUM  per-slot grant (combinational).
- alloc_idx_oh  out  ALLOC_NUM*ENTRY_NUM  one-hot index granted to each slot; slot k occupies bits [k*ENTRY_NUM +: ENTRY_NUM]; all-zero when that slot is not granted.
- alloc_idx_bin  out  ALLOC_NUM*AWIDTH  binary index granted to each slot; 0 when that slot is not granted.
- rel_vld  in  ENTRY_NUM  mask of entries released this cycle.
- busy  out  ENTRY_NUM  registered busy vector.
- used_cnt  out  AWIDTH+1  registered count of busy entries.
- full  out  1  used_cnt == ENTRY_NUM.
- empty  out  1  used_cnt == 0.
- rel_err  out  1  registered one-cycle pulse; set when a release targets a non-busy entry.

## Operation
- State: busy_q[ENTRY_NUM], cnt_q[AWIDTH:0], rel_err_q.
- Free vector: free = ~busy_q.
  - Entries released in the current cycle do not count as free until the next cycle.
- Slot search, processed in order k = 0..ALLOC_NUM-1:
  - avail_0 = free.
  - Slot k takes the first set bit of avail_k in the MSB_FIRST direction.
  - alloc_gnt[k] = alloc_req[k] and (avail_k != 0).
  - If slot k is granted, avail_{k+1} = avail_k with that entry cleared; otherwise avail_{k+1} = avail_k.
  - A non-requesting slot consumes nothing. Later requesting slots may still be granted (for example, req=2'b10 grants slot 1 the first free entry).
- Grants are always distinct entries. If fewer free entries exist than requesting slots, the lowest-numbered requesting slots win.
- Update on each edge:
  - busy_q ← (busy_q | granted_mask) & ~(rel_vld & busy_q).
  - cnt_q ← cnt_q + popcount(alloc_gnt) − popcount(rel_vld & busy_q).
- Invalid releases:
  - Release bits on non-busy entries are ignored for state and count.
  - Any such bit sets rel_err_q for exactly the next cycle.
- Release of an entry that was granted in the same cycle cannot occur: grants come only from free entries, and a release of a free entry is an error and is ignored.
- Invariant for verification: cnt_q == popcount(busy_q) at every cycle.

## Timing
- Grant path is combinational: alloc_req → alloc_gnt / alloc_idx_* in the same cycle.
- busy, used_cnt, full and empty reflect grants and releases one cycle after they occur.
- Back-to-back allocation: an entry granted in cycle N is not offered again in cycle N+1. Slot search uses busy_q, which already includes the cycle-N grant.
- Released entry: released in cycle N, first grantable in cycle N+1.
- Reset while rst=1:
  - busy=0, used_cnt=0, empty=1, full=0, rel_err=0.
  - alloc_gnt=0; alloc_req and rel_vld are ignored.
  - Reset asserted mid-operation discards all state on the next edge.
- Full: with free=0, every alloc_gnt=0. Releases still apply.
- Counter never wraps: maximum value is ENTRY_NUM, minimum is 0.

## Test plan
- Reset, then ENTRY_NUM=16, ALLOC_NUM=2, MSB_FIRST=1, req=2'b11 → slot0 idx 15, slot1 idx 14; next cycle busy=16'hC000, used_cnt=2.
- Same stimulus with MSB_FIRST=0 → slot0 idx 0, slot1 idx 1; then req=2'b10 → slot1 idx 2, slot0 not granted, idx_bin 0.
- Fill all 16 entries with req=2'b11 for 8 cycles → full=1 on cycle 9; further req gives gnt=0. Then release entry 7 → the following cycle grants idx 7 to slot0 only.
- Single free entry (busy=16'hFFFE) with req=2'b11 → slot0 gets idx 0, slot1 not granted; used_cnt goes 15→16.
- Release entry 3 while it is free → rel_err pulses for one cycle, and busy and used_cnt are unchanged. In the same cycle, release entry 5 while it is busy → entry 5 is cleared and used_cnt decrements by 1.
- Random requests and releases for 10k cycles with rst asserted mid-run → check used_cnt==popcount(busy), grants unique and free, and all outputs at reset values after the reset edge.

Source files
------------

// File: rtl/cmn_entry_alloc_multi.sv
// Multi-port entry allocator: busy/free tracking with up to ALLOC_NUM grants per cycle,
// selectable search direction, release mask and incremental occupancy counter.
module cmn_entry_alloc_multi #(
  parameter int ENTRY_NUM = 16,
  parameter int ALLOC_NUM = 2,
  parameter int MSB_FIRST = 1,
  localparam int AWIDTH = $clog2(ENTRY_NUM)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ALLOC_NUM-1:0]           alloc_req,
  output logic [ALLOC_NUM-1:0]           alloc_gnt,
  output logic [ALLOC_NUM*ENTRY_NUM-1:0] alloc_idx_oh,
  output logic [ALLOC_NUM*AWIDTH-1:0]    alloc_idx_bin,
  input  logic [ENTRY_NUM-1:0]           rel_vld,
  output logic [ENTRY_NUM-1:0]           busy,
  output logic [AWIDTH:0]                used_cnt,
  output logic                           full,
  output logic                           empty,
  output logic                           rel_err
);

  localparam logic [AWIDTH:0] FULL_CNT = (AWIDTH+1)'(ENTRY_NUM);

  logic [ENTRY_NUM-1:0]           r_busy;
  logic [AWIDTH:0]                r_cnt;
  logic                           r_full;
  logic                           r_empty;
  logic                           r_rel_err;

  logic [ALLOC_NUM-1:0]           w_gnt;
  logic [ALLOC_NUM*ENTRY_NUM-1:0] w_oh;
  logic [ALLOC_NUM*AWIDTH-1:0]    w_bin;
  logic [ENTRY_NUM-1:0]           w_gmask;
  logic [ENTRY_NUM-1:0]           w_rel_eff;
  logic                           w_rel_err;
  logic [AWIDTH:0]                w_cnt_nxt;

  function automatic logic [ENTRY_NUM-1:0] order(input logic [ENTRY_NUM-1:0] v);
    logic [ENTRY_NUM-1:0] r;
    r = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      r[i] = (MSB_FIRST != 0) ? v[ENTRY_NUM-1-i] : v[i];
    end
    return r;
  endfunction

  // Isolate lowest set bit in search order (bit-reversed when searching from the top).
  function automatic logic [ENTRY_NUM-1:0] first_free(input logic [ENTRY_NUM-1:0] v);
    logic [ENTRY_NUM-1:0] o;
    o = order(v);
    o = o & (~o + ENTRY_NUM'(1));
    return order(o);
  endfunction

  function automatic logic [AWIDTH-1:0] encode(input logic [ENTRY_NUM-1:0] v);
    logic [AWIDTH-1:0] idx;
    idx = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      idx = idx | (AWIDTH'(i) & {AWIDTH{v[i]}});
    end
    return idx;
  endfunction

  function automatic logic [AWIDTH:0] popcnt(input logic [ENTRY_NUM-1:0] v);
    logic [AWIDTH:0] c;
    c = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      c = c + {{AWIDTH{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Slot search: each granted slot removes its entry from what later slots can see.
  always_comb begin : p_search
    logic [ENTRY_NUM-1:0] avail;
    logic [ENTRY_NUM-1:0] pick;
    logic                 take;
    avail   = ~r_busy;
    pick    = '0;
    take    = 1'b0;
    w_gnt   = '0;
    w_oh    = '0;
    w_bin   = '0;
    w_gmask = '0;
    for (int k = 0; k < ALLOC_NUM; k++) begin
      pick     = first_free(avail);
      take     = ~rst & alloc_req[k] & (|avail);
      w_gnt[k] = take;
      w_oh[k*ENTRY_NUM +: ENTRY_NUM] = pick & {ENTRY_NUM{take}};
      w_bin[k*AWIDTH +: AWIDTH]      = encode(pick) & {AWIDTH{take}};
      w_gmask  = w_gmask | (pick & {ENTRY_NUM{take}});
      avail    = avail & ~(pick & {ENTRY_NUM{take}});
    end
  end

  // Releases of free entries are dropped from the state update and flagged instead.
  always_comb begin
    w_rel_eff = rel_vld & r_busy;
    w_rel_err = |(rel_vld & ~r_busy);
    w_cnt_nxt = r_cnt + popcnt(w_gmask) - popcnt(w_rel_eff);
  end

  // State registers; full/empty are registered alongside the counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy    <= '0;
      r_cnt     <= '0;
      r_full    <= 1'b0;
      r_empty   <= 1'b1;
      r_rel_err <= 1'b0;
    end else begin
      r_busy    <= (r_busy | w_gmask) & ~w_rel_eff;
      r_cnt     <= w_cnt_nxt;
      r_full    <= (w_cnt_nxt == FULL_CNT);
      r_empty   <= (w_cnt_nxt == '0);
      r_rel_err <= w_rel_err;
    end
  end

  assign alloc_gnt     = w_gnt;
  assign alloc_idx_oh  = w_oh;
  assign alloc_idx_bin = w_bin;
  assign busy          = r_busy;
  assign used_cnt      = r_cnt;
  assign full          = r_full;
  assign empty         = r_empty;
  assign rel_err       = r_rel_err;

endmodule

// File: tb/tb_cmn_entry_alloc_multi.sv
// Bench for cmn_entry_alloc_multi: two instances (top-first and bottom-first search) driven
// with shared stimulus and checked against a free-list queue reference model.
module tb_cmn_entry_alloc_multi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req = 2'b00;
  logic [15:0] rel = 16'h0000;

  always #5 clk = ~clk;

  logic [1:0]  g_h, g_l;
  logic [31:0] oh_h, oh_l;
  logic [7:0]  bin_h, bin_l;
  logic [15:0] busy_h, busy_l;
  logic [4:0]  cnt_h, cnt_l;
  logic        full_h, full_l, empty_h, empty_l, err_h, err_l;

  cmn_entry_alloc_multi #(.ENTRY_NUM(16), .ALLOC_NUM(2), .MSB_FIRST(1)) dut_h (
    .clk(clk), .rst(rst), .alloc_req(req), .alloc_gnt(g_h), .alloc_idx_oh(oh_h),
    .alloc_idx_bin(bin_h), .rel_vld(rel), .busy(busy_h), .used_cnt(cnt_h),
    .full(full_h), .empty(empty_h), .rel_err(err_h));

  cmn_entry_alloc_multi #(.ENTRY_NUM(16), .ALLOC_NUM(2), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .alloc_req(req), .alloc_gnt(g_l), .alloc_idx_oh(oh_l),
    .alloc_idx_bin(bin_l), .rel_vld(rel), .busy(busy_l), .used_cnt(cnt_l),
    .full(full_l), .empty(empty_l), .rel_err(err_l));

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  // Reference model state, index 0 = top-first instance, 1 = bottom-first instance
  logic [15:0] mb[2];
  logic        merr[2];
  logic [15:0] egm[2];
  logic [1:0]  eg[2];
  logic [31:0] eoh[2];
  logic [7:0]  ebin[2];

  // Combinational outputs captured in the most recent step
  logic [1:0]  lg_h, lg_l;
  logic [7:0]  lbin_h, lbin_l;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int popm(input logic [15:0] v);
    int c = 0;
    for (int i = 0; i < 16; i++) c += int'(v[i]);
    return c;
  endfunction

  // Free entries listed in priority order; each requesting slot pops the head.
  task automatic model_comb(input int m);
    int q[$];
    eg[m] = 2'b00; eoh[m] = 32'h0; ebin[m] = 8'h0; egm[m] = 16'h0;
    for (int n = 0; n < 16; n++) begin
      int i;
      i = (m == 0) ? 15 - n : n;
      if (!mb[m][i]) q.push_back(i);
    end
    for (int k = 0; k < 2; k++) begin
      if (!rst && req[k] && q.size() > 0) begin
        int e;
        e = q.pop_front();
        eg[m][k] = 1'b1;
        eoh[m][k*16 + e] = 1'b1;
        ebin[m][k*4 +: 4] = e[3:0];
        egm[m][e] = 1'b1;
      end
    end
  endtask

  task automatic model_seq(input int m);
    if (rst) begin
      mb[m] = 16'h0;
      merr[m] = 1'b0;
    end else begin
      merr[m] = |(rel & ~mb[m]);
      mb[m] = (mb[m] | egm[m]) & ~(rel & mb[m]);
    end
  endtask

  task automatic step(input logic [1:0] r, input logic [15:0] rl, input logic rs);
    req = r; rel = rl; rst = rs;
    @(negedge clk);
    model_comb(0); model_comb(1);
    lg_h = g_h; lg_l = g_l; lbin_h = bin_h; lbin_l = bin_l;
    chk("gnt_h", g_h, eg[0]);     chk("gnt_l", g_l, eg[1]);
    chk("oh_h", oh_h, eoh[0]);    chk("oh_l", oh_l, eoh[1]);
    chk("bin_h", bin_h, ebin[0]); chk("bin_l", bin_l, ebin[1]);
    if (!rst) begin
      chk("uniq_free_h", (oh_h[15:0] & oh_h[31:16]) | ((oh_h[15:0] | oh_h[31:16]) & busy_h), 0);
      chk("uniq_free_l", (oh_l[15:0] & oh_l[31:16]) | ((oh_l[15:0] | oh_l[31:16]) & busy_l), 0);
    end
    @(posedge clk);
    model_seq(0); model_seq(1);
    #1;
    chk("busy_h", busy_h, mb[0]);          chk("busy_l", busy_l, mb[1]);
    chk("cnt_h", cnt_h, popm(mb[0]));      chk("cnt_l", cnt_l, popm(mb[1]));
    chk("full_h", full_h, popm(mb[0]) == 16); chk("full_l", full_l, popm(mb[1]) == 16);
    chk("empty_h", empty_h, popm(mb[0]) == 0); chk("empty_l", empty_l, popm(mb[1]) == 0);
    chk("err_h", err_h, merr[0]);          chk("err_l", err_l, merr[1]);
    chk("inv_h", cnt_h, popm(busy_h));     chk("inv_l", cnt_l, popm(busy_l));
  endtask

  initial begin
    mb[0] = 16'h0; mb[1] = 16'h0; merr[0] = 1'b0; merr[1] = 1'b0;

    step(2'b00, 16'h0, 1'b1);
    step(2'b11, 16'hFFFF, 1'b1);
    chk("rst_empty", empty_h, 1'b1);

    // Two-slot grant in each direction
    step(2'b11, 16'h0, 1'b0);
    chk("tp1_gnt_h", lg_h, 2'b11);
    chk("tp1_bin_h", lbin_h, 8'hEF);
    chk("tp1_bin_l", lbin_l, 8'h10);
    chk("tp1_busy_h", busy_h, 16'hC000);
    chk("tp1_busy_l", busy_l, 16'h0003);
    chk("tp1_cnt_h", cnt_h, 5'd2);

    // Only slot 1 requests: it takes the first free entry
    step(2'b10, 16'h0, 1'b0);
    chk("tp2_gnt_l", lg_l, 2'b10);
    chk("tp2_bin_l", lbin_l, 8'h20);

    // Fill from reset
    step(2'b00, 16'h0, 1'b1);
    for (int i = 0; i < 8; i++) step(2'b11, 16'h0, 1'b0);
    chk("fill_full_h", full_h, 1'b1);
    chk("fill_full_l", full_l, 1'b1);
    chk("fill_cnt_h", cnt_h, 5'd16);
    step(2'b11, 16'h0, 1'b0);
    chk("full_nognt_h", lg_h, 2'b00);
    chk("full_nognt_l", lg_l, 2'b00);

    // Released entry becomes grantable next cycle
    step(2'b00, 16'h0080, 1'b0);
    step(2'b11, 16'h0, 1'b0);
    chk("rel7_gnt_h", lg_h, 2'b01);
    chk("rel7_bin_h", lbin_h, 8'h07);
    chk("rel7_bin_l", lbin_l, 8'h07);

    // Single free entry at index 0
    step(2'b00, 16'h0001, 1'b0);
    chk("one_free_busy", busy_h, 16'hFFFE);
    chk("one_free_cnt", cnt_h, 5'd15);
    step(2'b11, 16'h0, 1'b0);
    chk("one_free_gnt", lg_h, 2'b01);
    chk("one_free_bin", lbin_h, 8'h00);
    chk("one_free_cnt16", cnt_h, 5'd16);

    // Invalid release of entry 3 alongside a valid release of entry 5
    step(2'b00, 16'h0008, 1'b0);
    chk("rel3_noerr", err_h, 1'b0);
    step(2'b00, 16'h0028, 1'b0);
    chk("relerr_set", err_h, 1'b1);
    chk("relerr_busy", busy_h, 16'hFFD7);
    chk("relerr_cnt", cnt_h, 5'd14);
    step(2'b00, 16'h0, 1'b0);
    chk("relerr_clr", err_h, 1'b0);

    // Random traffic with resets
    for (int i = 0; i < 10000; i++) begin
      logic rs;
      rs = (i >= 5000 && i < 5002) || ($urandom_range(0, 1999) == 0);
      step(2'($urandom_range(0, 3)), 16'($urandom & $urandom), rs);
      if (rs) begin
        chk("rnd_rst_busy", busy_h, 16'h0);
        chk("rnd_rst_cnt", cnt_l, 5'd0);
        chk("rnd_rst_empty", empty_l, 1'b1);
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
